// File: rtl/encoder_frame_ctrl_pkg.sv
// Shared types and constants for the convolutional frame encoder.
// Holds the FSM state enum, the constraint-length limits and the
// per-K generator polynomial table used by the encoder core.
package encoder_frame_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int K_MIN  = 3;
    localparam int K_MAX  = 7;
    localparam int TAP_W  = K_MAX;      // u plus K_MAX-1 state bits
    localparam int SREG_W = K_MAX - 1;  // widest encoder state

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [TAP_W-1:0] g0;
        logic [TAP_W-1:0] g1;
    } gen_pair_t;

    // Generator pair for constraint length k. Bit k-1 taps the input bit,
    // bit 0 taps the oldest state bit. Illegal k yields all-zero taps.
    function automatic gen_pair_t gen_table(input logic [2:0] k);
        gen_pair_t gp;
        case (k)
            3'd3:    begin gp.g0 = 7'o7;   gp.g1 = 7'o5;   end
            3'd4:    begin gp.g0 = 7'o17;  gp.g1 = 7'o15;  end
            3'd5:    begin gp.g0 = 7'o23;  gp.g1 = 7'o35;  end
            3'd6:    begin gp.g0 = 7'o53;  gp.g1 = 7'o75;  end
            3'd7:    begin gp.g0 = 7'o171; gp.g1 = 7'o133; end
            default: begin gp.g0 = 7'o0;   gp.g1 = 7'o0;   end
        endcase
        return gp;
    endfunction

    // Even parity (XOR reduction) of a masked tap vector.
    function automatic logic tap_parity(input logic [TAP_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/encoder_frame_ctrl_if.sv
// Byte-in / symbol-out handshake bundle for the frame encoder.
// master = frame source and symbol sink, slave = the encoder.
interface encoder_frame_ctrl_if;
    import encoder_frame_ctrl_pkg::*;

    logic              start;
    logic [BYTE_W-1:0] frame_len;
    logic [2:0]        choose_constraint_length;
    logic [BYTE_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [1:0]        sym;
    logic              sym_valid;
    logic              sym_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, frame_len, choose_constraint_length, din, din_valid, sym_ready,
        input  din_ready, sym, sym_valid, busy, done, err
    );

    modport slave (
        input  start, frame_len, choose_constraint_length, din, din_valid, sym_ready,
        output din_ready, sym, sym_valid, busy, done, err
    );

endinterface

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder core with selectable K (3..7).
// State s[K-2] is the newest bit, s[0] the oldest. The parity pair is
// combinational from (u, s); the state shifts only when en is high.
module conv_enc_core
    import encoder_frame_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] k,
    input  logic       u,
    output logic [1:0] par
);

    logic [SREG_W-1:0] s_q;
    logic [SREG_W-1:0] s_d;
    logic [SREG_W-1:0] shift_s;
    logic [TAP_W-1:0]  s_ext_s;
    logic [TAP_W-1:0]  tap_s;
    gen_pair_t         gen_s;

    assign gen_s   = gen_table(k);
    assign shift_s = s_q >> 1;
    assign s_ext_s = {1'b0, s_q};

    // Build the K-bit tap vector {u, s[K-2:0]} and the shifted next state.
    always_comb begin
        tap_s = '0;
        s_d   = '0;
        for (int i = 0; i < TAP_W; i++) begin
            if (i == int'(k) - 1) begin
                tap_s[i] = u;
            end else if (i < int'(k) - 1) begin
                tap_s[i] = s_ext_s[i];
            end else begin
                tap_s[i] = 1'b0;
            end
        end
        for (int i = 0; i < SREG_W; i++) begin
            if (i == int'(k) - 2) begin
                s_d[i] = u;
            end else if (i < int'(k) - 2) begin
                s_d[i] = shift_s[i];
            end else begin
                s_d[i] = 1'b0;
            end
        end
    end

    assign par = {tap_parity(tap_s & gen_s.g0), tap_parity(tap_s & gen_s.g1)};

    // Encoder state register: cleared at frame start, shifts on each advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else if (clr) begin
            s_q <= '0;
        end else if (en) begin
            s_q <= s_d;
        end else begin
            s_q <= s_q;
        end
    end

endmodule

// File: rtl/encoder_frame_ctrl.sv
// Frame controller for the convolutional encoder: accepts a frame header,
// serialises each byte MSB first into the encoder, appends K-1 zero tail
// bits and presents each parity pair through a registered valid/ready port.
module encoder_frame_ctrl
    import encoder_frame_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    encoder_frame_ctrl_if.slave  bus
);

    state_e            state_q;
    logic [BYTE_W-1:0] len_q;
    logic [2:0]        k_q;
    logic [BYTE_W-1:0] byte_q;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        tail_cnt_q;
    logic [1:0]        sym_q;
    logic              sym_valid_q;
    logic              din_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              advance_s;
    logic              enc_en_s;
    logic              enc_u_s;
    logic              start_ok_s;
    logic [1:0]        par_s;

    // A new encoder bit may enter only when the output register is free
    // or is being emptied this cycle.
    assign advance_s  = ~sym_valid_q | bus.sym_ready;
    assign enc_en_s   = advance_s & ((state_q == ST_SHIFT) | (state_q == ST_TAIL));
    assign enc_u_s    = (state_q == ST_SHIFT) ? byte_q[bit_cnt_q] : 1'b0;
    assign start_ok_s = (state_q == ST_IDLE) & bus.start
                      & (bus.frame_len != 8'd0)
                      & (bus.choose_constraint_length >= 3'(K_MIN));

    conv_enc_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok_s),
        .en    (enc_en_s),
        .k     (k_q),
        .u     (enc_u_s),
        .par   (par_s)
    );

    // Frame FSM, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd0;
            k_q         <= 3'd0;
            byte_q      <= 8'd0;
            bit_cnt_q   <= 3'd0;
            tail_cnt_q  <= 3'd0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (enc_en_s) begin
                sym_q       <= par_s;
                sym_valid_q <= 1'b1;
            end else if (bus.sym_ready) begin
                sym_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        len_q       <= bus.frame_len;
                        k_q         <= bus.choose_constraint_length;
                        din_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end else if (bus.start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.din_valid && din_ready_q) begin
                        byte_q      <= bus.din;
                        bit_cnt_q   <= 3'd7;
                        din_ready_q <= 1'b0;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (advance_s) begin
                        if (bit_cnt_q == 3'd0) begin
                            if (len_q == 8'd1) begin
                                len_q      <= 8'd0;
                                tail_cnt_q <= k_q - 3'd2;
                                state_q    <= ST_TAIL;
                            end else begin
                                len_q       <= len_q - 8'd1;
                                din_ready_q <= 1'b1;
                                state_q     <= ST_LOAD;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (advance_s) begin
                        if (tail_cnt_q == 3'd0) begin
                            state_q <= ST_DONE;
                        end else begin
                            tail_cnt_q <= tail_cnt_q - 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // The last tail symbol is still in the output register here.
                    if (sym_valid_q && bus.sym_ready) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    din_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sym       = sym_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.din_ready = din_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: doc/encoder_frame_ctrl.md
ENCODER_FRAME_CTRL -- requirements
Module: encoder_frame_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-004 frame_len  input  8  data bytes in frame, 1..255; sampled with start.
REQ-005 choose_constraint_length  input  3  K, legal 3..7; sampled with start.
REQ-006 din  input  8  data byte, serialized MSB first.
REQ-007 din_valid / din_ready  input / output  1 each  byte handshake; transfer when both high on a clock edge.
REQ-008 sym  output  2  encoded pair; sym[1] = g0 parity, sym[0] = g1 parity.
REQ-009 sym_valid / sym_ready  output / input  1 each  symbol handshake; transfer when both high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the last tail symbol transfers.
REQ-012 err  output  1  one-cycle pulse on rejected start.

Function
REQ-013 States: IDLE, LOAD, SHIFT, TAIL, DONE.
REQ-014 IDLE: start with frame_len=0 or K<3 -> stay IDLE, err=1 next cycle; legal start -> latch len and K, clear encoder state, go to LOAD.
REQ-015 LOAD: din_ready=1; on transfer, capture byte, bit counter=7, go to SHIFT; din_ready=0 in all other states.
REQ-016 SHIFT: one bit enters the encoder per "advance" cycle; advance = (sym_valid==0) or sym_ready.
REQ-017 SHIFT, after bit 0 advances: if bytes remain -> LOAD, else -> TAIL with tail counter = K-2.
REQ-018 TAIL: feed zero bits on advance, K-1 total, then go to DONE.
REQ-019 DONE: hold until the final symbol transfers; then done=1 for one cycle and return to IDLE.
REQ-020 Encoder state: K-1 bits; s[K-2] newest, s[0] oldest. On advance: outputs computed from (u, s), then s shifts right and s[K-2]=u.
REQ-021 Generators (octal, MSB tap = u, LSB tap = s[0]): K3 7/5, K4 17/15, K5 23/35, K6 53/75, K7 171/133.
REQ-022 Parity bit = XOR of tapped bits.
REQ-023 Latency: sym is registered and valid the cycle after its input bit advances; sym and sym_valid stay stable while sym_valid=1 and sym_ready=0.
REQ-024 Throughput: one symbol per cycle with sym_ready held high; a LOAD bubble of at least one cycle per byte is permitted.
REQ-025 Frame output = 8*frame_len + (K-1) symbols exactly.
REQ-026 start outside IDLE is ignored, with no err.
REQ-027 din_valid stall in LOAD: no symbols are produced; encoder state is held.
REQ-028 sym_ready low: encoder state, counters and FSM are frozen until advance.

Reset
REQ-029 rst=0 asynchronously forces: IDLE; encoder state 0; counters 0; sym=00; sym_valid=0; din_ready=0; busy=0; done=0; err=0.
REQ-030 Reset mid-frame abandons the frame; no done pulse; the first cycle after release accepts start.

Structure
REQ-031 Shared package: state enum; K_MIN=3, K_MAX=7; per-K generator table; byte-width constant.
REQ-032 Sub-module conv_enc_core holds state, polynomial select, enable and synchronous clear, and produces the 2-bit parity combinationally; encoder_frame_ctrl owns the FSM, counters and output register.

Verification
REQ-033 K=3, len=1, din=0x80, sym_ready=1 -> syms 11,10,11,00,00,00,00,00,00,00; done 1 cycle after the 10th.
REQ-034 start with frame_len=0, and separately K=2 -> err pulse, busy stays 0, no din_ready.
REQ-035 K=7, len=2 -> exactly 22 symbols, matching the reference model.
REQ-036 Random sym_ready backpressure, K=5, len=4 -> symbol sequence identical to the no-backpressure run; sym stable while stalled.
REQ-037 din_valid low for 5 cycles between bytes -> no symbols emitted during the gap; sequence unchanged.
REQ-038 rst asserted during TAIL -> all outputs reset immediately; next legal start produces a correct full frame.
